// File: rtl/adc_capture_pkg.sv
// Purpose: shared constants for the ADC frame capture block (register map, bit positions, widths).
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: register byte offsets, CTRL/STATUS/DATA bit positions, default sample width,
//           FIFO entry width helper (flag bit + sample).
package adc_capture_pkg;

   localparam int DATA_W_DEF  = 10;
   localparam int ENTRY_W_DEF = DATA_W_DEF + 1;

   // Byte offsets from the block base address
   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_DATA   = 4'h8;
   localparam logic [3:0] OFF_THRESH = 4'hC;

   // CTRL bits
   localparam int CTRL_EN     = 0;
   localparam int CTRL_FLUSH  = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bits
   localparam int ST_EMPTY    = 8;
   localparam int ST_FULL     = 9;
   localparam int ST_OVF      = 10;
   localparam int ST_SHORT    = 11;
   localparam int ST_DROP_LSB = 16;

   // DATA bits
   localparam int DATA_VALID = 31;
   localparam int DATA_FLAG  = 16;

   // FIFO entry is {pixel_flag, sample}
   function automatic int entry_w(input int data_w);
      return data_w + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with push, pop, one-cycle flush and a registered fill level.
// Latency: a push is visible in o_level/o_pop_dat after 1 cycle; o_pop_dat is the head, read combinationally.
// Backpressure: none upstream; push on full is refused unless a pop happens in the same cycle. Flush beats both.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_push_dat, i_pop, i_flush,
//        o_pop_dat (head entry), o_full, o_empty, o_level (0..DEPTH).
module sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_dat,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic [WIDTH-1:0]           o_pop_dat,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [LW-1:0]    r_count;

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   assign w_full  = (r_count == LW'(DEPTH));
   assign w_empty = (r_count == '0);

   // A pop frees the slot the push needs, so push on full is fine when paired with a pop.
   assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
   assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_push_dat;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_pop_dat = r_mem[r_rptr];
   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_level   = r_count;

endmodule

// File: rtl/adc_frame_capture.sv
// Purpose: capture framed serial ADC words tagged with the pixel flag into a FIFO drained over Wishbone.
// Latency: last sclk pin edge -> STATUS.level in 5 cycles; Wishbone accesses take 1 wait state.
// Backpressure: none on the ADC side; a sample arriving at a full FIFO is dropped, flagged (ovf) and counted.
// Ports: i_wb_clk/i_wb_rst (sync, active-high), Wishbone classic slave (i_wb_cyc/stb/we/addr/data,
//        o_wb_ack/o_wb_data), async ADC inputs (i_adc_frame, i_adc_sclk, i_adc_sdata, i_pixel_flag),
//        o_irq level interrupt on FIFO fill threshold.
module adc_frame_capture
   import adc_capture_pkg::*;
#(
   parameter int          DATA_W     = DATA_W_DEF,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0100
) (
   input  logic        i_wb_clk,
   input  logic        i_wb_rst,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_data,
   input  logic        i_adc_frame,
   input  logic        i_adc_sclk,
   input  logic        i_adc_sdata,
   input  logic        i_pixel_flag,
   output logic        o_irq
);

   localparam int EW = entry_w(DATA_W);
   localparam int CW = $clog2(DATA_W + 1);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

   // ---------------------------------------------------------------- input capture
   logic r_frame_m, r_frame_s, r_frame_d;
   logic r_sclk_m,  r_sclk_s,  r_sclk_d, r_sclk_rise;
   logic r_sdata_m, r_sdata_s;
   logic r_flag_m,  r_flag_s;

   logic w_frame_rise;
   logic w_frame_fall;

   assign w_frame_rise = r_frame_s & ~r_frame_d;
   assign w_frame_fall = ~r_frame_s & r_frame_d;

   // ---------------------------------------------------------------- deserializer state
   logic [DATA_W-1:0] r_shift;
   logic [CW-1:0]     r_cnt;
   logic              r_armed;
   logic              r_push;
   logic [EW-1:0]     r_push_dat;
   logic              r_short_evt;

   // ---------------------------------------------------------------- register file state
   logic        r_ack;
   logic [31:0] r_rdata;
   logic        r_en;
   logic        r_irq_en;
   logic [3:0]  r_thresh;
   logic        r_ovf;
   logic        r_short;
   logic [7:0]  r_drop_cnt;

   // ---------------------------------------------------------------- FIFO
   logic [EW-1:0] w_head;
   logic          w_full;
   logic          w_empty;
   logic [LW-1:0] w_level;
   logic [3:0]    w_level4;
   logic          w_pop;
   logic          w_flush;
   logic          w_drop;

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         r_frame_m   <= 1'b0;
         r_frame_s   <= 1'b0;
         r_frame_d   <= 1'b0;
         r_sclk_m    <= 1'b0;
         r_sclk_s    <= 1'b0;
         r_sclk_d    <= 1'b0;
         r_sclk_rise <= 1'b0;
         r_sdata_m   <= 1'b0;
         r_sdata_s   <= 1'b0;
         r_flag_m    <= 1'b0;
         r_flag_s    <= 1'b0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_armed     <= 1'b0;
         r_push      <= 1'b0;
         r_push_dat  <= '0;
         r_short_evt <= 1'b0;
      end else begin
         r_frame_m   <= i_adc_frame;
         r_frame_s   <= r_frame_m;
         r_frame_d   <= r_frame_s;
         r_sclk_m    <= i_adc_sclk;
         r_sclk_s    <= r_sclk_m;
         r_sclk_d    <= r_sclk_s;
         r_sclk_rise <= r_sclk_s & ~r_sclk_d;
         r_sdata_m   <= i_adc_sdata;
         r_sdata_s   <= r_sdata_m;
         r_flag_m    <= i_pixel_flag;
         r_flag_s    <= r_flag_m;

         r_push      <= 1'b0;
         r_short_evt <= 1'b0;

         // r_armed ensures a frame already in flight when enable (or reset) changes is never
         // captured half-way; only a fresh frame rising edge while enabled starts a word.
         if (!r_en) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
         end else if (w_frame_rise) begin
            r_armed <= 1'b1;
            r_cnt   <= '0;
            r_shift <= '0;
         end else if (w_frame_fall) begin
            if (r_armed && (r_cnt != '0) && (r_cnt != CNT_FULL)) begin
               r_short_evt <= 1'b1;
            end
            r_cnt   <= '0;
            r_shift <= '0;
         end else if (r_armed && r_frame_s && r_sclk_rise && (r_cnt != CNT_FULL)) begin
            // Counter parks at DATA_W so surplus edges in the same frame are ignored.
            r_shift <= {r_shift[DATA_W-2:0], r_sdata_s};
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
               r_push     <= 1'b1;
               r_push_dat <= {r_flag_s, r_shift[DATA_W-2:0], r_sdata_s};
            end
         end
      end
   end

   // ---------------------------------------------------------------- Wishbone decode
   logic       w_hit;
   logic       w_access;
   logic       w_wr;
   logic       w_rd;
   logic [3:0] w_off;

   assign w_hit    = (i_wb_addr[31:4] == BASE_ADDR[31:4]);
   assign w_off    = {i_wb_addr[3:2], 2'b00};
   // Blocking on r_ack makes each held cyc&stb produce exactly one ack pulse.
   assign w_access = i_wb_cyc & i_wb_stb & ~r_ack & w_hit;
   assign w_wr     = w_access & i_wb_we;
   assign w_rd     = w_access & ~i_wb_we;

   // Pop and flush act on the same edge that raises ack, so the next access already sees the result.
   assign w_pop   = w_rd & (w_off == OFF_DATA) & ~w_empty;
   assign w_flush = w_wr & (w_off == OFF_CTRL) & i_wb_data[CTRL_FLUSH];
   assign w_drop  = r_push & w_full & ~w_pop & ~w_flush;

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (i_wb_clk),
      .i_rst      (i_wb_rst),
      .i_push     (r_push),
      .i_push_dat (r_push_dat),
      .i_pop      (w_pop),
      .i_flush    (w_flush),
      .o_pop_dat  (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_level    (w_level)
   );

   assign w_level4 = 4'(w_level);

   logic [31:0] w_status;
   logic [31:0] w_data_word;
   logic [31:0] w_rmux;

   always_comb begin
      w_status                       = '0;
      w_status[3:0]                  = w_level4;
      w_status[ST_EMPTY]             = w_empty;
      w_status[ST_FULL]              = w_full;
      w_status[ST_OVF]               = r_ovf;
      w_status[ST_SHORT]             = r_short;
      w_status[ST_DROP_LSB +: 8]     = r_drop_cnt;
   end

   always_comb begin
      w_data_word = '0;
      if (!w_empty) begin
         w_data_word[DATA_VALID]   = 1'b1;
         w_data_word[DATA_FLAG]    = w_head[DATA_W];
         w_data_word[DATA_W-1:0]   = w_head[DATA_W-1:0];
      end
   end

   always_comb begin
      w_rmux = '0;
      case (w_off)
         OFF_CTRL: begin
            w_rmux[CTRL_EN]     = r_en;
            w_rmux[CTRL_IRQ_EN] = r_irq_en;
         end
         OFF_STATUS: w_rmux = w_status;
         OFF_DATA:   w_rmux = w_data_word;
         OFF_THRESH: w_rmux[3:0] = r_thresh;
         default:    w_rmux = '0;
      endcase
   end

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         r_ack      <= 1'b0;
         r_rdata    <= '0;
         r_en       <= 1'b0;
         r_irq_en   <= 1'b0;
         r_thresh   <= 4'd1;
         r_ovf      <= 1'b0;
         r_short    <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_ack   <= w_access;
         r_rdata <= w_rd ? w_rmux : '0;

         if (w_wr) begin
            case (w_off)
               OFF_CTRL: begin
                  r_en     <= i_wb_data[CTRL_EN];
                  r_irq_en <= i_wb_data[CTRL_IRQ_EN];
               end
               OFF_STATUS: begin
                  if (i_wb_data[ST_OVF]) begin
                     r_ovf <= 1'b0;
                  end
                  if (i_wb_data[ST_SHORT]) begin
                     r_short <= 1'b0;
                  end
                  r_drop_cnt <= '0;
               end
               OFF_THRESH: r_thresh <= i_wb_data[3:0];
               default: ;
            endcase
         end

         // New events win over a coincident software clear.
         if (r_short_evt) begin
            r_short <= 1'b1;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
               r_drop_cnt <= r_drop_cnt + 8'd1;
            end
         end
      end
   end

   assign o_wb_ack  = r_ack;
   assign o_wb_data = r_rdata;
   assign o_irq     = r_irq_en & (w_level4 >= r_thresh) & (r_thresh != 4'd0);

   logic w_unused;
   assign w_unused = &{1'b0, i_wb_data[31:12], i_wb_data[9:4], i_wb_addr[1:0]};

endmodule

// File: doc/adc_frame_capture.md
# adc_frame_capture

Downstream consumer of the pixel sequencer in `designs_wrapper`. It captures the serial ADC word framed by the sequencer's ADC-frame strobe and tags each sample with the pixel flag. Samples are buffered in a small FIFO that the management core drains over Wishbone. Optionally, the block raises an interrupt when a FIFO fill threshold is reached.

## Interface
Parameters:
- `DATA_W`, 10: ADC sample width in bits, MSB first on the serial line.
- `FIFO_DEPTH`, 8: sample FIFO entries; must be a power of 2.
- `BASE_ADDR`, 32'h3000_0100: Wishbone base address; bits [3:0] must be 0.

Ports:
- `i_wb_clk`, in, 1: the only clock.
- `i_wb_rst`, in, 1: reset, synchronous, active-high.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we`, in, 1 each: Wishbone classic slave controls.
- `i_wb_addr`, in, 32: byte address.
- `i_wb_data`, in, 32: write data.
- `o_wb_ack`, out, 1: Wishbone acknowledge.
- `o_wb_data`, out, 32: read data.
- `i_adc_frame`, in, 1: frame window from the sequencer; asynchronous to `i_wb_clk`.
- `i_adc_sclk`, in, 1: serial bit clock; asynchronous.
- `i_adc_sdata`, in, 1: serial data, valid at the rising edge of `i_adc_sclk`; asynchronous.
- `i_pixel_flag`, in, 1: pixel flag from the sequencer; asynchronous.
- `o_irq`, out, 1: level interrupt.

## Operation
- Input capture:
  - Each of the four async inputs passes through its own 2-flop synchronizer.
  - A rising edge of `i_adc_sclk` is detected on the synced value by comparing it with a third delay flop.
- Deserializer (only while CTRL.enable = 1):
  - While frame_s = 1, each sclk rising edge shifts sdata_s into the shift register and increments the bit counter.
  - When the counter reaches `DATA_W`, push {pixel_flag_s, sample} into the FIFO. Any further edges in the same frame are ignored.
  - On a frame_s falling edge with a count in 1..DATA_W-1, set STATUS.short (sticky) and discard the partial word.
  - The counter clears on every frame_s rising edge.
- CTRL.enable = 0: the shift register and counter are held at 0 and no pushes occur. The FIFO remains readable.
- FIFO full:
  - A push with no simultaneous pop is dropped, STATUS.ovf is set (sticky), and drop_cnt increments, saturating at 255.
  - Push and pop in the same cycle are both accepted, including when full. The level is unchanged.
- Flush (a CTRL write with bit1 = 1): empties the FIFO in one cycle. If a push coincides, flush wins and the push is lost without being counted.
- Register map (word offsets from `BASE_ADDR`):
  - 0x0 CTRL, R/W:
    - bit0 enable, reset 0.
    - bit1 flush, self-clearing, always reads 0.
    - bit2 irq_en, reset 0.
  - 0x4 STATUS, R:
    - [3:0] level.
    - bit8 empty.
    - bit9 full.
    - bit10 ovf, write-1-to-clear.
    - bit11 short, write-1-to-clear.
    - [23:16] drop_cnt; any write to STATUS clears it.
  - 0x8 DATA, R:
    - bit31 valid.
    - bit16 pixel flag.
    - [DATA_W-1:0] sample.
    - A read pops one entry. A read when empty returns 0 and does not pop. Writes are ignored.
  - 0xC THRESH, R/W: [3:0] threshold, reset 1.
- `o_irq` = irq_en & (level ≥ threshold) & (threshold ≠ 0).

## Timing
- Wishbone:
  - The block decodes only when i_wb_addr[31:4] == BASE_ADDR[31:4]. A miss produces no ack.
  - `o_wb_ack` is a 1-cycle pulse, asserted the cycle after cyc&stb with no ack in the previous cycle. This gives 1 wait state.
  - `o_wb_data` is valid with ack and is 0 otherwise.
  - A DATA read pops in the ack cycle, so a back-to-back read sees the next entry.
- Capture latency: the last sclk rising edge at the pin results in the FIFO entry being visible in STATUS.level 5 cycles later: 2 sync, 1 edge detect, 1 push, 1 level register.
- Input constraint: `i_adc_sclk` high and low time must each be ≥ 3 `i_wb_clk` cycles. Frame must set up ≥ 1 sclk period before the first edge.
- Reset values: `o_wb_ack` 0, `o_wb_data` 0, `o_irq` 0, FIFO empty, all sticky bits and drop_cnt 0, CTRL 0, THRESH 1.
- A reset mid-frame discards the partial word. Deserializing resumes only at the next frame_s rising edge after enable is set.

## Structure
- Package `adc_capture_pkg`: register offsets, STATUS/CTRL bit positions, `DATA_W` default, FIFO entry width (DATA_W+1).
- Sub-module `sync_fifo`, parameterized by width and depth. It provides push, pop, flush, full, empty and level, with simultaneous push/pop on full permitted.
- Top level: synchronizers, deserializer, and the Wishbone register file.

## Test plan
- Enable, then send frame with sdata 10'h2A5 MSB-first, pixel_flag = 1 -> DATA read returns 32'h8001_02A5. STATUS.level then drops from 1 to 0.
- Frame containing only 6 sclk edges -> STATUS.short = 1 and level = 0. Writing 1 to STATUS bit11 clears it.
- 11 frames into an 8-entry FIFO with no reads -> full = 1, ovf = 1, drop_cnt = 3. Eight DATA reads return the first 8 samples in order.
- THRESH = 4, irq_en = 1, push 3 samples -> o_irq = 0. On the 4th push, o_irq = 1. One DATA read returns o_irq to 0.
- Read DATA when empty -> returns 0 and level stays 0. Access to BASE_ADDR+0x10 -> no ack.
- Assert `i_wb_rst` mid-frame after 5 bits, then enable and send a full frame -> exactly one entry is captured, holding the new sample.
